// File: rtl/sobel_pkg.sv
// Shared state encodings for the sobel_uc control unit.
// db_estado exposes these codes directly.
package sobel_pkg;

  localparam int ST_W = 4;

  typedef enum logic [ST_W-1:0] {
    OCIOSO    = 4'd0,
    RECEBE    = 4'd1,
    CALCULA   = 4'd2,
    TX_INICIA = 4'd3,
    TX_ESPERA = 4'd4,
    FIM       = 4'd5,
    ERRO      = 4'd15
  } state_t;

endpackage

// File: rtl/sobel_uc.sv
// Control unit sequencing one receive / Sobel compute / transmit frame.
// Optional receive watchdog compiled in with SOBEL_UC_TIMEOUT_EN.
module sobel_uc
  import sobel_pkg::*;
#(
  parameter int IMG_W          = 64,
  parameter int IMG_H          = 64,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            iniciar,
  input  logic            rx_pronto,
  input  logic            sobel_fim_imagem,
  input  logic            tx_pronto,
  output logic            rx_enable,
  output logic            sobel_calcula,
  output logic            tx_partida,
  output logic            tx_enable,
  output logic            pronto,
  output logic            erro,
  output logic [ST_W-1:0] db_estado
);

  localparam int RX_TOTAL = IMG_W * IMG_H;
  localparam int TX_TOTAL = (IMG_W - 2) * (IMG_H - 2);
  localparam int CNT_W    = $clog2(RX_TOTAL + 1);

  localparam logic [CNT_W-1:0] RX_LAST = CNT_W'(RX_TOTAL - 1);
  localparam logic [CNT_W-1:0] TX_END  = CNT_W'(TX_TOTAL);

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] rx_cnt;
  logic [CNT_W-1:0] tx_cnt;
  logic [CNT_W-1:0] tx_cnt_inc;
  logic             frame_go;
  logic             wd_hit;

  assign frame_go   = (state == OCIOSO) && iniciar;
  assign tx_cnt_inc = tx_cnt + CNT_W'(1);

`ifdef SOBEL_UC_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;

  assign wd_hit = (wd_cnt == WD_W'(TIMEOUT_CYCLES));

  // Idle time is measured only while waiting for bytes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if (frame_go) begin
      wd_cnt <= '0;
    end else if (state == RECEBE) begin
      if (rx_pronto)
        wd_cnt <= '0;
      else if (!wd_hit)
        wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

  assign erro = (state == ERRO);
`else
  logic unused_timeout;

  assign unused_timeout = |TIMEOUT_CYCLES;
  assign wd_hit         = 1'b0;
  assign erro           = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      state <= OCIOSO;
    else
      state <= state_n;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_cnt <= '0;
      tx_cnt <= '0;
    end else if (frame_go) begin
      rx_cnt <= '0;
      tx_cnt <= '0;
    end else begin
      if (state == RECEBE && rx_pronto)
        rx_cnt <= rx_cnt + CNT_W'(1);
      if (state == TX_ESPERA && tx_pronto)
        tx_cnt <= tx_cnt_inc;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      OCIOSO: begin
        if (iniciar)
          state_n = RECEBE;
      end
      RECEBE: begin
        if (wd_hit)
          state_n = ERRO;
        else if (rx_pronto && rx_cnt == RX_LAST)
          state_n = CALCULA;
      end
      CALCULA: begin
        if (sobel_fim_imagem)
          state_n = TX_INICIA;
      end
      TX_INICIA: state_n = TX_ESPERA;
      TX_ESPERA: begin
        if (tx_pronto)
          state_n = (tx_cnt_inc == TX_END) ? FIM : TX_INICIA;
      end
      FIM:     state_n = OCIOSO;
      ERRO:    state_n = ERRO;
      default: state_n = OCIOSO;
    endcase
  end

  assign rx_enable     = (state == RECEBE);
  assign sobel_calcula = (state == CALCULA);
  assign tx_partida    = (state == TX_INICIA);
  assign tx_enable     = (state == TX_INICIA) || (state == TX_ESPERA);
  assign pronto        = (state == FIM);
  assign db_estado     = state;

endmodule

// File: tb/tb_sobel_uc.sv
// Self-checking bench for sobel_uc on a 4x4 image.
// Define SOBEL_UC_TIMEOUT_EN on both RTL and bench to check the watchdog.
module tb_sobel_uc;

  localparam int W        = 4;
  localparam int H        = 4;
  localparam int TO       = 100;
  localparam int RX_TOTAL = W * H;
  localparam int TX_TOTAL = (W - 2) * (H - 2);

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0;
  logic       rx_pronto = 1'b0;
  logic       sobel_fim_imagem = 1'b0;
  logic       tx_pronto = 1'b0;
  logic       rx_enable;
  logic       sobel_calcula;
  logic       tx_partida;
  logic       tx_enable;
  logic       pronto;
  logic       erro;
  logic [3:0] db_estado;

  int errors = 0;
  int checks = 0;
  int n_partida = 0;
  int n_pronto = 0;
  int to_cnt;
  bit ok;

  sobel_uc #(
    .IMG_W(W),
    .IMG_H(H),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .iniciar(iniciar),
    .rx_pronto(rx_pronto),
    .sobel_fim_imagem(sobel_fim_imagem),
    .tx_pronto(tx_pronto),
    .rx_enable(rx_enable),
    .sobel_calcula(sobel_calcula),
    .tx_partida(tx_partida),
    .tx_enable(tx_enable),
    .pronto(pronto),
    .erro(erro),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (tx_partida === 1'b1) n_partida++;
    if (pronto === 1'b1) n_pronto++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic pulse_rx();
    rx_pronto = 1'b1;
    tick(1);
    rx_pronto = 1'b0;
  endtask

  task automatic start_frame();
    iniciar = 1'b1;
    tick(1);
    iniciar = 1'b0;
  endtask

  task automatic send_rx(input int n);
    for (int i = 0; i < n; i++) begin
      tick($urandom_range(0, 2));
      pulse_rx();
    end
  endtask

  task automatic calc_done();
    tick($urandom_range(0, 4));
    sobel_fim_imagem = 1'b1;
    tick(1);
    sobel_fim_imagem = 1'b0;
  endtask

  task automatic wait_partida(output bit found);
    int k = 0;
    while (tx_partida !== 1'b1 && k < 20) begin
      tick(1);
      k++;
    end
    found = (tx_partida === 1'b1);
  endtask

  // Answers each transmitter start with a tx_pronto after a random latency.
  task automatic serve_tx(input int n, output int timeouts);
    bit f;
    timeouts = 0;
    for (int i = 0; i < n; i++) begin
      wait_partida(f);
      if (!f) timeouts++;
      tick(1 + $urandom_range(0, 3));
      tx_pronto = 1'b1;
      tick(1);
      tx_pronto = 1'b0;
    end
  endtask

  task automatic wait_pronto(output bit found);
    int k = 0;
    while (pronto !== 1'b1 && k < 20) begin
      tick(1);
      k++;
    end
    found = (pronto === 1'b1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(2);
    checks++;
    if (db_estado !== 4'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d expected 0", db_estado);
    end
    checks++;
    if ({rx_enable, sobel_calcula, tx_partida, tx_enable, pronto, erro} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 000000",
        {rx_enable, sobel_calcula, tx_partida, tx_enable, pronto, erro});
    end
    reset = 1'b0;
    tick(3);
    checks++;
    if (db_estado !== 4'd0) begin
      errors++;
      $display("FAIL idle_hold: got %0d expected 0", db_estado);
    end
  endtask

  task automatic test_nominal();
    n_partida = 0;
    n_pronto  = 0;
    start_frame();
    checks++;
    if (db_estado !== 4'd1 || rx_enable !== 1'b1) begin
      errors++;
      $display("FAIL nom_recebe: got st=%0d rx_en=%b expected st=1 rx_en=1",
        db_estado, rx_enable);
    end
    send_rx(RX_TOTAL);
    checks++;
    if (db_estado !== 4'd2 || sobel_calcula !== 1'b1 || rx_enable !== 1'b0) begin
      errors++;
      $display("FAIL nom_calcula: got st=%0d calc=%b rx_en=%b expected 2 1 0",
        db_estado, sobel_calcula, rx_enable);
    end
    calc_done();
    checks++;
    if (db_estado !== 4'd3 || tx_partida !== 1'b1 || tx_enable !== 1'b1) begin
      errors++;
      $display("FAIL nom_tx_inicia: got st=%0d part=%b en=%b expected 3 1 1",
        db_estado, tx_partida, tx_enable);
    end
    tick(1);
    checks++;
    if (db_estado !== 4'd4 || tx_partida !== 1'b0 || tx_enable !== 1'b1) begin
      errors++;
      $display("FAIL nom_tx_espera: got st=%0d part=%b en=%b expected 4 0 1",
        db_estado, tx_partida, tx_enable);
    end
    tick($urandom_range(0, 3));
    tx_pronto = 1'b1;
    tick(1);
    tx_pronto = 1'b0;
    serve_tx(TX_TOTAL - 1, to_cnt);
    checks++;
    if (to_cnt !== 0) begin
      errors++;
      $display("FAIL nom_tx_timeout: got %0d expected 0", to_cnt);
    end
    wait_pronto(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL nom_pronto_seen: got 0 expected 1");
    end
    tick(1);
    checks++;
    if (db_estado !== 4'd0 || pronto !== 1'b0) begin
      errors++;
      $display("FAIL nom_back_idle: got st=%0d pronto=%b expected 0 0",
        db_estado, pronto);
    end
    checks++;
    if (n_partida !== TX_TOTAL || n_pronto !== 1) begin
      errors++;
      $display("FAIL nom_pulses: got part=%0d pronto=%0d expected %0d 1",
        n_partida, n_pronto, TX_TOTAL);
    end
  endtask

  task automatic test_rx_boundary();
    n_partida = 0;
    start_frame();
    send_rx(RX_TOTAL - 1);
    checks++;
    if (db_estado !== 4'd1) begin
      errors++;
      $display("FAIL rxb_15: got %0d expected 1", db_estado);
    end
    tick(3);
    checks++;
    if (db_estado !== 4'd1) begin
      errors++;
      $display("FAIL rxb_15_hold: got %0d expected 1", db_estado);
    end
    pulse_rx();
    checks++;
    if (db_estado !== 4'd2) begin
      errors++;
      $display("FAIL rxb_16: got %0d expected 2", db_estado);
    end
    calc_done();
    serve_tx(TX_TOTAL, to_cnt);
    wait_pronto(ok);
    tick(1);
    checks++;
    if (!ok || db_estado !== 4'd0 || n_partida !== TX_TOTAL) begin
      errors++;
      $display("FAIL rxb_frame: got ok=%b st=%0d part=%0d expected 1 0 %0d",
        ok, db_estado, n_partida, TX_TOTAL);
    end
  endtask

  task automatic test_reset_mid();
    bit f;
    start_frame();
    send_rx(RX_TOTAL);
    calc_done();
    serve_tx(2, to_cnt);
    wait_partida(f);
    tick(1);
    checks++;
    if (!f || db_estado !== 4'd4) begin
      errors++;
      $display("FAIL mid_pre: got found=%b st=%0d expected 1 4", f, db_estado);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (db_estado !== 4'd0 ||
        {rx_enable, sobel_calcula, tx_partida, tx_enable, pronto, erro} !== 6'b0) begin
      errors++;
      $display("FAIL mid_reset: got st=%0d outs=%b expected 0 000000", db_estado,
        {rx_enable, sobel_calcula, tx_partida, tx_enable, pronto, erro});
    end
    tick(1);
    reset = 1'b0;
    tick(1);
    n_partida = 0;
    n_pronto  = 0;
    start_frame();
    send_rx(RX_TOTAL - 1);
    checks++;
    if (db_estado !== 4'd1) begin
      errors++;
      $display("FAIL mid_new_rx15: got %0d expected 1", db_estado);
    end
    pulse_rx();
    calc_done();
    serve_tx(TX_TOTAL, to_cnt);
    wait_pronto(ok);
    tick(1);
    checks++;
    if (!ok || n_partida !== TX_TOTAL || n_pronto !== 1) begin
      errors++;
      $display("FAIL mid_new_frame: got ok=%b part=%0d pronto=%0d expected 1 %0d 1",
        ok, n_partida, n_pronto, TX_TOTAL);
    end
  endtask

  task automatic test_ignored();
    n_partida = 0;
    n_pronto  = 0;
    iniciar = 1'b1;
    tick(1);
    checks++;
    if (db_estado !== 4'd1) begin
      errors++;
      $display("FAIL ign_start: got %0d expected 1", db_estado);
    end
    send_rx(RX_TOTAL);
    repeat (5) begin
      tick($urandom_range(0, 2));
      pulse_rx();
    end
    tx_pronto = 1'b1;
    tick(1);
    tx_pronto = 1'b0;
    checks++;
    if (db_estado !== 4'd2 || sobel_calcula !== 1'b1) begin
      errors++;
      $display("FAIL ign_stray: got st=%0d calc=%b expected 2 1",
        db_estado, sobel_calcula);
    end
    calc_done();
    serve_tx(TX_TOTAL, to_cnt);
    wait_pronto(ok);
    tick(1);
    checks++;
    if (!ok || db_estado !== 4'd0) begin
      errors++;
      $display("FAIL ign_idle: got ok=%b st=%0d expected 1 0", ok, db_estado);
    end
    tick(1);
    checks++;
    if (db_estado !== 4'd1) begin
      errors++;
      $display("FAIL ign_restart: got %0d expected 1", db_estado);
    end
    checks++;
    if (n_partida !== TX_TOTAL || n_pronto !== 1) begin
      errors++;
      $display("FAIL ign_pulses: got part=%0d pronto=%0d expected %0d 1",
        n_partida, n_pronto, TX_TOTAL);
    end
    iniciar = 1'b0;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic test_watchdog();
    start_frame();
    send_rx(3);
    tick(TO - 5);
    checks++;
    if (db_estado !== 4'd1 || erro !== 1'b0) begin
      errors++;
      $display("FAIL wd_before: got st=%0d erro=%b expected 1 0", db_estado, erro);
    end
`ifdef SOBEL_UC_TIMEOUT_EN
    begin
      int k = 0;
      while (erro !== 1'b1 && k < 20) begin
        tick(1);
        k++;
      end
    end
    checks++;
    if (erro !== 1'b1 || db_estado !== 4'd15) begin
      errors++;
      $display("FAIL wd_erro: got st=%0d erro=%b expected 15 1", db_estado, erro);
    end
    checks++;
    if ({rx_enable, sobel_calcula, tx_partida, tx_enable, pronto} !== 5'b0) begin
      errors++;
      $display("FAIL wd_outs: got %b expected 00000",
        {rx_enable, sobel_calcula, tx_partida, tx_enable, pronto});
    end
    start_frame();
    pulse_rx();
    tick(5);
    checks++;
    if (db_estado !== 4'd15 || erro !== 1'b1) begin
      errors++;
      $display("FAIL wd_sticky: got st=%0d erro=%b expected 15 1", db_estado, erro);
    end
`else
    tick(200);
    checks++;
    if (db_estado !== 4'd1 || erro !== 1'b0) begin
      errors++;
      $display("FAIL wd_absent: got st=%0d erro=%b expected 1 0", db_estado, erro);
    end
`endif
    reset = 1'b1;
    #1;
    checks++;
    if (db_estado !== 4'd0 || erro !== 1'b0) begin
      errors++;
      $display("FAIL wd_reset: got st=%0d erro=%b expected 0 0", db_estado, erro);
    end
    tick(1);
    reset = 1'b0;
    tick(1);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_rx_boundary();
    test_reset_mid();
    test_ignored();
    test_nominal();
    test_watchdog();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/sobel_uc.md
SOBEL_UC -- requirements
Module: sobel_uc

Interface
REQ-001 SHALL have parameter IMG_W, default 64, image width in pixels (bytes); legal range 3..256.
REQ-002 SHALL have parameter IMG_H, default 64, image height in pixels; legal range 3..256.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 50_000_000, maximum idle clock cycles between received bytes.
REQ-004 SHALL have port clock, input, 1, single system clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-006 SHALL have port iniciar, input, 1, level; starts one receive/compute/transmit frame when sampled high in OCIOSO.
REQ-007 SHALL have port rx_pronto, input, 1, one-cycle pulse per byte received by the serial receiver.
REQ-008 SHALL have port sobel_fim_imagem, input, 1, high when the processing unit has finished the image.
REQ-009 SHALL have port tx_pronto, input, 1, one-cycle pulse when the serial transmitter finishes a byte.
REQ-010 SHALL have port rx_enable, output, 1, gates the serial line into the receiver.
REQ-011 SHALL have port sobel_calcula, output, 1, commands the processing unit to compute.
REQ-012 SHALL have port tx_partida, output, 1, one-cycle start pulse to the transmitter.
REQ-013 SHALL have port tx_enable, output, 1, lets the processing unit drive tx_dados.
REQ-014 SHALL have port pronto, output, 1, one-cycle pulse at frame completion.
REQ-015 SHALL have port erro, output, 1, level; high while in ERRO.
REQ-016 SHALL have port db_estado, output, 4, current state encoding.

Function
REQ-017 SHALL implement states and codes: OCIOSO=0, RECEBE=1, CALCULA=2, TX_INICIA=3, TX_ESPERA=4, FIM=5, ERRO=15.
REQ-018 SHALL go OCIOSO->RECEBE on iniciar=1, clearing rx_cnt and tx_cnt to 0.
REQ-019 SHALL, in RECEBE, assert rx_enable and increment rx_cnt on each rx_pronto.
REQ-020 SHALL go RECEBE->CALCULA on the rx_pronto that brings rx_cnt to IMG_W*IMG_H; extra rx_pronto pulses outside RECEBE are ignored.
REQ-021 SHALL, in CALCULA, hold sobel_calcula=1 and go to TX_INICIA when sobel_fim_imagem=1.
REQ-022 SHALL, in TX_INICIA, assert tx_partida and tx_enable for exactly one cycle and go to TX_ESPERA unconditionally.
REQ-023 SHALL, in TX_ESPERA, hold tx_enable=1; on tx_pronto increment tx_cnt, then go to FIM if the new tx_cnt equals (IMG_W-2)*(IMG_H-2), else to TX_INICIA.
REQ-024 SHALL pulse pronto for one cycle in FIM and return to OCIOSO the next cycle, regardless of iniciar.
REQ-025 SHALL, in ERRO, hold erro=1 and all other outputs 0, and leave ERRO only via reset.
REQ-026 SHALL size rx_cnt and tx_cnt to $clog2(IMG_W*IMG_H+1) bits; the counters never wrap.
REQ-027 SHALL drive all outputs as Moore outputs of the registered state; iniciar asserted while busy has no effect.

Reset
REQ-028 SHALL, on reset=1 (asynchronous), force state OCIOSO, clear both counters and the timeout counter, and drive rx_enable=0, sobel_calcula=0, tx_partida=0, tx_enable=0, pronto=0, erro=0, and db_estado=0; reset mid-frame abandons the frame.

Configuration
REQ-029 SHALL compile a receive watchdog when SOBEL_UC_TIMEOUT_EN is defined; the watchdog counter clears on entering RECEBE and on each rx_pronto, counts otherwise in RECEBE, and moves the FSM to ERRO when the count reaches TIMEOUT_CYCLES.
REQ-030 SHALL, without SOBEL_UC_TIMEOUT_EN, contain no watchdog logic; RECEBE waits indefinitely, ERRO is unreachable, and erro is tied to 0.

Structure
REQ-031 SHALL take the state encodings and the db_estado width from shared package sobel_pkg.
REQ-032 SHALL be a single FSM module with no sub-modules; byte counters are inline.

Verification
REQ-033 SHALL cover the nominal frame: IMG_W=IMG_H=4, iniciar pulse, 16 rx_pronto pulses, then sobel_fim_imagem, then 4 tx_pronto pulses -> exactly 4 tx_partida pulses and one pronto pulse, then OCIOSO.
REQ-034 SHALL cover the receive boundary: 15 rx_pronto pulses -> state stays RECEBE (db_estado=1); the 16th pulse -> CALCULA on the next cycle.
REQ-035 SHALL cover reset mid-frame: reset asserted in TX_ESPERA with tx_cnt=2 -> all outputs 0 immediately, and a new frame then counts from 0.
REQ-036 SHALL cover the watchdog: SOBEL_UC_TIMEOUT_EN defined, TIMEOUT_CYCLES=100, no rx_pronto for 100 cycles in RECEBE -> erro=1 and db_estado=15 until reset; without the macro -> remains in RECEBE.
REQ-037 SHALL cover ignored inputs: iniciar held high through a whole frame, plus stray rx_pronto pulses in CALCULA -> counts unchanged, and the FSM runs exactly one frame per OCIOSO entry.
